// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : 16 x 16 Conway Game of Life engine (B3/S23). One 256-bit grid
//               register advances one generation per clock while run is high.
//               Cells outside the grid count as dead (no wrap-around).
// Revision    : 1.0 - initial release
// ============================================================================
module datapath (
    input  logic         clk,
    output logic [255:0] grid_evolve,
    input  logic [255:0] initial_state,
    input  logic         run,
    input  logic         reset
);

    // Grid geometry. The padded frame adds one dead cell on every side so
    // that edge and corner cells can use the same neighbour sum as interior
    // cells without any special-casing.
    localparam int C_ROWS  = 16;
    localparam int C_COLS  = 16;
    localparam int C_PCOLS = C_COLS + 2;
    localparam int C_PROWS = C_ROWS + 2;
    localparam int C_PBITS = C_PROWS * C_PCOLS;

    logic [255:0]         r_grid;
    logic [255:0]         w_next;
    logic [C_PBITS-1:0]   w_pad;

    // Top and bottom dead border rows of the padded frame.
    assign w_pad[C_PCOLS-1:0]                = '0;
    assign w_pad[C_PBITS-1 -: C_PCOLS]       = '0;

    genvar r, c;

    // Each grid row sits between a dead cell on its left and on its right.
    generate
        for (r = 0; r < C_ROWS; r = r + 1) begin : g_pad_row
            assign w_pad[C_PCOLS*(r+1) +: C_PCOLS] =
                {1'b0, r_grid[C_COLS*r +: C_COLS], 1'b0};
        end
    endgenerate

    // Every cell's next state is derived only from the current register, so
    // all 256 updates happen in parallel with no intra-generation coupling.
    generate
        for (r = 0; r < C_ROWS; r = r + 1) begin : g_row
            for (c = 0; c < C_COLS; c = c + 1) begin : g_col
                localparam int C_CTR = C_PCOLS*(r+1) + (c+1);
                logic [3:0] w_cnt;
                logic       w_alive;

                assign w_alive = r_grid[C_COLS*r + c];

                // Sum of the eight neighbours, zero-extended to 4 bits so the
                // full 0..8 range is representable.
                assign w_cnt = {3'b000, w_pad[C_CTR - C_PCOLS - 1]}
                             + {3'b000, w_pad[C_CTR - C_PCOLS]}
                             + {3'b000, w_pad[C_CTR - C_PCOLS + 1]}
                             + {3'b000, w_pad[C_CTR - 1]}
                             + {3'b000, w_pad[C_CTR + 1]}
                             + {3'b000, w_pad[C_CTR + C_PCOLS - 1]}
                             + {3'b000, w_pad[C_CTR + C_PCOLS]}
                             + {3'b000, w_pad[C_CTR + C_PCOLS + 1]};

                // Birth on exactly three, survival on two or three.
                assign w_next[C_COLS*r + c] =
                    (w_cnt == 4'd3) | (w_alive & (w_cnt == 4'd2));
            end
        end
    endgenerate

    // Grid register: reset loads the seed (overriding run), run advances one
    // generation, otherwise the current generation is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grid <= initial_state;
        end else if (run) begin
            r_grid <= w_next;
        end
    end

    assign grid_evolve = r_grid;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath. A behavioural Game of Life
//               model computes every expected grid from the B3/S23 rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    logic         clk;
    logic         reset;
    logic         run;
    logic [255:0] initial_state;
    logic [255:0] grid_evolve;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] C_PAT = {4{64'h0412_6424_0034_3C28}};

    datapath u_dut (
        .clk           (clk),
        .grid_evolve   (grid_evolve),
        .initial_state (initial_state),
        .run           (run),
        .reset         (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one generation computed cell by cell from the rules.
    function automatic logic [255:0] life_step(input logic [255:0] g);
        logic [255:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 16 &&
                            cc >= 0 && cc < 16 && g[rr*16+cc])
                            cnt++;
                    end
                end
                n[r*16+c] = (cnt == 3) || (g[r*16+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [255:0] rand_grid();
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom();
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [255:0] seed);
        reset         = 1'b1;
        initial_state = seed;
        tick();
        reset         = 1'b0;
    endtask

    task automatic test_reset();
        logic [255:0] q;
        q = rand_grid();
        reset = 1'b1; run = 1'b1; initial_state = q;
        tick();
        checks++;
        if (grid_evolve !== q) begin
            errors++;
            $display("FAIL reset_load got %h want %h", grid_evolve, q);
        end
        initial_state = C_PAT;
        tick();
        checks++;
        if (grid_evolve !== C_PAT) begin
            errors++;
            $display("FAIL reset_track got %h want %h", grid_evolve, C_PAT);
        end
        reset = 1'b0; run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            initial_state = rand_grid();
            tick();
            checks++;
            if (grid_evolve !== C_PAT) begin
                errors++;
                $display("FAIL hold cyc %0d got %h want %h", i, grid_evolve, C_PAT);
            end
        end
    endtask

    task automatic test_blinker();
        logic [255:0] seed, vert;
        seed = 256'(16'h01C0) << 112;
        vert = (256'(16'h0080) << 96) | (256'(16'h0080) << 112) |
               (256'(16'h0080) << 128);
        load(seed);
        run = 1'b1;
        tick();
        checks++;
        if (grid_evolve !== vert) begin
            errors++;
            $display("FAIL blinker_p1 got %h want %h", grid_evolve, vert);
        end
        tick();
        checks++;
        if (grid_evolve !== seed) begin
            errors++;
            $display("FAIL blinker_p2 got %h want %h", grid_evolve, seed);
        end
    endtask

    task automatic test_still_life();
        logic [255:0] blk;
        blk = 256'h0003_0003;
        load(blk);
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (grid_evolve !== blk) begin
                errors++;
                $display("FAIL still cyc %0d got %h want %h", i, grid_evolve, blk);
            end
        end
    endtask

    task automatic test_no_wrap();
        logic [255:0] exp_g, corner;
        load(256'h0007);
        run = 1'b1;
        tick();
        exp_g = 256'h0002_0002;
        checks++;
        if (grid_evolve !== exp_g) begin
            errors++;
            $display("FAIL nowrap_row0 got %h want %h", grid_evolve, exp_g);
        end
        corner = '0;
        corner[255] = 1'b1;
        load(corner);
        tick();
        checks++;
        if (grid_evolve !== '0) begin
            errors++;
            $display("FAIL nowrap_corner got %h want 0", grid_evolve);
        end
        // Three cells hugging column 15 of row 8: wrap would wrongly feed column 0.
        load(256'(16'h8000) << 112 | 256'(16'h8000) << 128 | 256'(16'h8000) << 144);
        tick();
        exp_g = (256'(16'hC000) << 128);
        checks++;
        if (grid_evolve !== exp_g) begin
            errors++;
            $display("FAIL nowrap_col15 got %h want %h", grid_evolve, exp_g);
        end
    endtask

    task automatic test_zero();
        load('0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            initial_state = rand_grid();
            tick();
            checks++;
            if (grid_evolve !== '0) begin
                errors++;
                $display("FAIL zero cyc %0d got %h want 0", i, grid_evolve);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] exp_g, seed2;
        exp_g = 256'(16'h01C0) << 112;
        load(exp_g);
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_g = life_step(exp_g);
            checks++;
            if (grid_evolve !== exp_g) begin
                errors++;
                $display("FAIL midrst_run %0d got %h want %h", i, grid_evolve, exp_g);
            end
        end
        seed2 = rand_grid();
        reset = 1'b1; initial_state = seed2;
        tick();
        checks++;
        if (grid_evolve !== seed2) begin
            errors++;
            $display("FAIL midrst_load got %h want %h", grid_evolve, seed2);
        end
        reset = 1'b0;
        exp_g = seed2;
        for (int i = 0; i < 3; i++) begin
            initial_state = rand_grid();
            tick();
            exp_g = life_step(exp_g);
            checks++;
            if (grid_evolve !== exp_g) begin
                errors++;
                $display("FAIL midrst_resume %0d got %h want %h", i, grid_evolve, exp_g);
            end
        end
    endtask

    task automatic test_random();
        logic [255:0] exp_g;
        for (int s = 0; s < 20; s++) begin
            exp_g = rand_grid();
            if (s[0]) exp_g = exp_g & rand_grid();
            load(exp_g);
            for (int i = 0; i < 30; i++) begin
                run = ($urandom_range(0, 3) != 0);
                initial_state = rand_grid();
                tick();
                if (run) exp_g = life_step(exp_g);
                checks++;
                if (grid_evolve !== exp_g) begin
                    errors++;
                    $display("FAIL random s%0d c%0d got %h want %h",
                             s, i, grid_evolve, exp_g);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        initial_state = '0;
        test_reset();
        test_blinker();
        test_still_life();
        test_no_wrap();
        test_zero();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameters: none; grid size fixed at 16 x 16 cells (256 bits).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on rising edge of clk.
REQ-004 initial_state  input  256  seed pattern loaded into the grid during reset.
REQ-005 run  input  1  evolution enable; 1 = advance one generation per clock, 0 = hold.
REQ-006 grid_evolve  output  256  current grid; driven directly from the state register.
REQ-007 Port order SHALL be (clk, grid_evolve, initial_state, run, reset) for positional instantiation.
REQ-008 Bit mapping: row r (0..15) = bits [16r+15 : 16r]; column c (0..15) = bit 16r+c; 1 = live cell, 0 = dead cell.

Function
REQ-009 The block SHALL hold one 256-bit grid register; grid_evolve SHALL equal that register with no combinational path from inputs.
REQ-010 Each cell's neighbour count SHALL be the number of live cells among its 8 adjacent positions (row +/-1, column +/-1), range 0..8, using at least 4-bit arithmetic.
REQ-011 Next-state rule (Conway B3/S23): live cell with 2 or 3 live neighbours stays live; dead cell with exactly 3 live neighbours becomes live; every other cell becomes or stays dead.
REQ-012 Boundary: positions outside rows 0..15 or columns 0..15 SHALL count as dead; there is no wrap-around, and row 0, row 15, column 0, column 15 and the four corners SHALL use only their in-grid neighbours.
REQ-013 All 256 next-state values SHALL be computed combinationally from the current register in parallel; no cell update may use another cell's already-updated value.
REQ-014 When reset=0 and run=1, the register SHALL load the next generation on each rising edge, giving a latency of exactly one clock per generation.
REQ-015 When reset=0 and run=0, the register SHALL hold its value indefinitely.
REQ-016 initial_state SHALL be ignored whenever reset=0; changes to it while running SHALL have no effect.
REQ-017 An all-zero grid SHALL remain all-zero under run=1.

Reset
REQ-018 On a rising edge with reset=1, the register SHALL load initial_state, overriding run.
REQ-019 Reset asserted mid-evolution SHALL discard the current generation and reload initial_state on the next rising edge.
REQ-020 While reset remains 1, grid_evolve SHALL track initial_state as sampled on each rising edge.
REQ-021 Before the first reset edge, grid_evolve is undefined; there is no asynchronous clear.

Verification
REQ-022 Load/hold: reset=1 with initial_state = 0412_6424_0034_3C28 repeated four times, then reset=0, run=0 for 5 cycles -> grid_evolve equals that pattern on every cycle.
REQ-023 Blinker: seed row 7 = 16'h01C0, other rows zero, run=1 -> after 1 clock rows 6, 7 and 8 = 16'h0080, other rows zero; after 2 clocks the seed pattern returns.
REQ-024 Still life: seed rows 0 and 1 = 16'h0003, other rows zero, run=1 for 10 clocks -> unchanged every cycle.
REQ-025 No wrap: seed row 0 = 16'h0007, run=1 -> after 1 clock rows 0 and 1 = 16'h0002 and row 15 = 16'h0000; a single live cell at bit 255 -> all-zero after 1 clock.
REQ-026 Mid-run reset: run=1 with a blinker for 3 clocks, then reset=1 for one edge -> grid_evolve equals initial_state on that edge, resumes evolving from it once reset=0.
